// File: rtl/rv_mul_pkg.sv
// Shared definitions for the pipelined RISC-V M-extension multiplier:
// op encoding, pipeline latency and Booth sizing helpers.
package rv_mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  localparam int unsigned MUL_LAT = 4;

  // Radix-4 digits needed to cover a w-bit signed multiplier.
  function automatic int unsigned booth_digits(input int unsigned w);
    return w / 2 + 1;
  endfunction

  function automatic logic a_is_signed(input mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic b_is_signed(input mul_op_e op);
    return op == MULH;
  endfunction

endpackage

// File: rtl/kogge_stone.sv
// N-bit Kogge-Stone parallel-prefix adder (carry-in 0, carry-out dropped).
module kogge_stone #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);

  logic [N-1:0] g, p, gn, pn;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gn = g;
    pn = p;
    for (int unsigned d = 1; d < N; d = d * 2) begin
      gn = g;
      pn = p;
      for (int unsigned i = d; i < N; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    sum = a ^ b ^ {g[N-2:0], 1'b0};
  end

endmodule

// File: rtl/rv_mul_ppgen.sv
// Radix-4 Booth recoder: W-bit signed operands to booth_digits(W) partial
// products, each already shifted and sign-extended to 2*(W-1) bits.
module rv_mul_ppgen
  import rv_mul_pkg::*;
#(
  parameter  int unsigned W   = 33,
  localparam int unsigned PW  = 2 * (W - 1),
  localparam int unsigned NPP = booth_digits(W)
) (
  input  logic [W-1:0]              a,
  input  logic [W-1:0]              b,
  output logic [NPP-1:0][PW-1:0]    pp
);

  localparam int unsigned BX = 2 * NPP + 1;

  logic [PW-1:0] a_sx;
  logic [PW-1:0] term;
  logic [BX-1:0] bx;
  logic [2:0]    trip;

  always_comb begin
    a_sx = {{(PW-W){a[W-1]}}, a};
    // Multiplier sign-extended to an even width, with the implicit b[-1]=0.
    bx   = {{(BX-W-1){b[W-1]}}, b, 1'b0};
    term = '0;
    trip = '0;
    pp   = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      trip = bx[2*i +: 3];
      case (trip)
        3'b001, 3'b010: term = a_sx;
        3'b011:         term = a_sx << 1;
        3'b100:         term = -(a_sx << 1);
        3'b101, 3'b110: term = -a_sx;
        default:        term = '0;
      endcase
      pp[i] = term << (2 * i);
    end
  end

endmodule

// File: rtl/rv_mul_pipe.sv
// Four-stage valid/ready multiplier for MUL/MULH/MULHSU/MULHU with tag sideband.
// Optional synchronous pipeline flush input when RV_MUL_FLUSH_EN is defined.
module rv_mul_pipe
  import rv_mul_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
`ifdef RV_MUL_FLUSH_EN
  input  logic             flush,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned W   = XLEN + 1;
  localparam int unsigned PW  = 2 * XLEN;
  localparam int unsigned NPP = booth_digits(W);

  logic                    adv;
  mul_op_e                 op_in;

  logic                    s1_valid, s2_valid, s3_valid;
  mul_op_e                 s1_op, s2_op, s3_op;
  logic [TAG_W-1:0]        s1_tag, s2_tag, s3_tag;
  logic [W-1:0]            s1_a, s1_b;
  logic [NPP-1:0][PW-1:0]  pp_c, s2_pp;
  logic [PW-1:0]           cs_s, cs_c, cs_t;
  logic [PW-1:0]           s3_sum, s3_carry;
  logic [PW-1:0]           prod;
  logic [XLEN-1:0]         res_sel;

  assign op_in = mul_op_e'(in_op);
  assign adv   = out_ready || !out_valid;

`ifdef RV_MUL_FLUSH_EN
  assign in_ready = adv && !flush;
`else
  assign in_ready = adv;
`endif

  rv_mul_ppgen #(.W(W)) u_ppgen (
    .a  (s1_a),
    .b  (s1_b),
    .pp (pp_c)
  );

  // Linear chain of 3:2 compressors reducing all partial products to sum/carry.
  always_comb begin
    cs_s = '0;
    cs_c = '0;
    cs_t = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      cs_t = cs_s ^ cs_c ^ s2_pp[i];
      cs_c = ((cs_s & cs_c) | (cs_s & s2_pp[i]) | (cs_c & s2_pp[i])) << 1;
      cs_s = cs_t;
    end
  end

  kogge_stone #(.N(PW)) u_final_add (
    .a   (s3_sum),
    .b   (s3_carry),
    .sum (prod)
  );

  assign res_sel = (s3_op == MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
`ifdef RV_MUL_FLUSH_EN
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
`endif
    end else if (adv) begin
      s1_valid  <= in_valid && in_ready;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
    end
  end

  // Output data only loads on a real result so bubbles leave it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_op    <= MUL;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_op    <= MUL;
      s2_tag   <= '0;
      s2_pp    <= '0;
      s3_op    <= MUL;
      s3_tag   <= '0;
      s3_sum   <= '0;
      s3_carry <= '0;
      out_res  <= '0;
      out_tag  <= '0;
    end else if (adv) begin
      s1_op    <= op_in;
      s1_tag   <= in_tag;
      s1_a     <= {a_is_signed(op_in) & in_a[XLEN-1], in_a};
      s1_b     <= {b_is_signed(op_in) & in_b[XLEN-1], in_b};
      s2_op    <= s1_op;
      s2_tag   <= s1_tag;
      s2_pp    <= pp_c;
      s3_op    <= s2_op;
      s3_tag   <= s2_tag;
      s3_sum   <= cs_s;
      s3_carry <= cs_c;
      if (s3_valid) begin
        out_res <= res_sel;
        out_tag <= s3_tag;
      end
    end
  end

endmodule

// File: tb/tb_rv_mul_pipe.sv
// Directed self-checking bench for rv_mul_pipe (XLEN=32); exercises the flush
// input too when RV_MUL_FLUSH_EN is defined.
module tb_rv_mul_pipe;
  import rv_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_tag;
`ifdef RV_MUL_FLUSH_EN
  logic        flush;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  mul_op_e     t_op [6] = '{MUL, MULHU, MULH, MULHSU, MULHSU, MULH};
  logic [31:0] t_a  [6] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'h7FFFFFFF};
  logic [31:0] t_b  [6] = '{32'd5, 32'd2, 32'd2, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
  logic [31:0] t_r  [6] = '{32'h0000000F, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hC0000000, 32'h3FFFFFFF};

  always #5 clk = ~clk;

  rv_mul_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
`ifdef RV_MUL_FLUSH_EN
    .flush     (flush),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Offer one op until accepted; leaves in_valid high for back-to-back use.
  task automatic send(input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tg, input logic [31:0] r);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tg;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        exp_q.push_back('{r, tg});
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic measure(input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, input logic [31:0] r);
    int first = 0;
    int cnt   = 0;
    send(op, a, b, tg, r);
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt++;
        if (first == 0) first = k;
      end
      @(posedge clk);
      #1;
    end
    check("latency", 64'(first), 64'(MUL_LAT));
    check("pulse_count", 64'(cnt), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: every presented result must match the oldest outstanding op.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        check("res", 64'(out_res), 64'(exp_q[0].res));
        check("tag", 64'(out_tag), 64'(exp_q[0].tag));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
`ifdef RV_MUL_FLUSH_EN
    flush     = 1'b0;
`endif
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_res", 64'(out_res), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single op: latency, value, and exactly one valid pulse.
    measure(MUL, 32'd7, 32'hFFFFFFFD, 5'h0A, 32'hFFFFFFEB);

    // High-half corner products, back to back.
    send(MULH,   32'h80000000, 32'h80000000, 5'd1, 32'h40000000);
    send(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
    send(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF);
    in_valid = 1'b0;
    wait_drain("drain_corner");

    // Six back-to-back ops with a 3-cycle output stall at the first result.
    fork
      begin
        for (int i = 0; i < 6; i++) send(t_op[i], t_a[i], t_b[i], 5'(i), t_r[i]);
        in_valid = 1'b0;
      end
      begin
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
          @(posedge clk);
          #1;
          if (out_valid) found = 1'b1;
        end
        check("stall_first_valid", 64'(found), 64'd1);
        if (found) begin
          out_ready = 1'b0;
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
          end
          out_ready = 1'b1;
        end
      end
    join
    wait_drain("drain_stall");

    // Reset with operations in flight discards them all.
    out_ready = 1'b0;
    send(MUL, 32'd2, 32'd3, 5'd7,  32'd6);
    send(MUL, 32'd4, 32'd5, 5'd8,  32'd20);
    send(MUL, 32'd6, 32'd7, 5'd9,  32'd42);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_res", 64'(out_res), 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("post_rst_valids", 64'(cnt), 64'd0);

`ifdef RV_MUL_FLUSH_EN
    @(posedge clk);
    #1;
    send(MUL, 32'd10, 32'd11, 5'd20, 32'd110);
    send(MUL, 32'd12, 32'd13, 5'd21, 32'd156);
    send(MUL, 32'd14, 32'd15, 5'd22, 32'd210);
    in_op  = MUL;
    in_a   = 32'd9;
    in_b   = 32'd9;
    in_tag = 5'd23;
    flush  = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("post_flush_valids", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    measure(MULHU, 32'h80000000, 32'h00000004, 5'd24, 32'h00000002);
`endif

    repeat (3) @(posedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
